vpg_pattern_sequencer: RTL

- Control-side scheduler for the VGA test-pattern generator's 8-bit pattern register.
- Avalon master to the generator's slave (cs_n/write/read, 8-bit data); Avalon slave to the Nios host.
- Auto-cycles patterns 0..NUM_PATTERNS-1, each held DWELL frames, or applies host-selected manual patterns.
- All pattern writes land at vertical-sync start, so pattern changes never tear a frame.

---
 rtl/vpg_pattern_sequencer.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/vpg_pattern_sequencer.sv
// Frame-synchronous scheduler for the VGA test-pattern generator's pattern register.
// Define VPG_SEQ_READBACK_EN to add a read-back verify of every pattern write.
module vpg_pattern_sequencer #(
    parameter int         NUM_PATTERNS  = 6,
    parameter logic [7:0] DEFAULT_DWELL = 8'd60
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       s_cs_n,
    input  logic [1:0] s_address,
    input  logic       s_write,
    input  logic [7:0] s_writedata,
    input  logic       s_read,
    output logic [7:0] s_readdata,
    input  logic       vga_vs,
    output logic       m_cs_n,
    output logic       m_write,
    output logic [7:0] m_writedata,
    output logic       m_read,
    input  logic [7:0] m_readdata,
    output logic       frame_tick
);

    localparam logic [2:0] LAST_PAT = 3'(NUM_PATTERNS - 1);

    typedef enum logic [1:0] {IDLE, WR, RD, CHK} state_t;

    state_t     state_q, state_d;
    logic       vs_meta_q, vs_sync_q, vs_prev_q, frame_tick_q;
    logic       auto_en_q, auto_en_d;
    logic [2:0] manual_q, manual_d;
    logic       manual_pending_q, manual_pending_d;
    logic [7:0] dwell_q, dwell_d;
    logic [2:0] cur_pattern_q, cur_pattern_d;
    logic [7:0] frame_cnt_q, frame_cnt_d;
    logic       err_q, err_d;
    logic [2:0] target_q, target_d;
    logic [7:0] s_readdata_q, s_readdata_d;

    logic       host_wr, host_rd, busy, dwell_hit;
    logic [7:0] dwell_eff, rd_mux;
    logic [2:0] next_pattern;
    logic       unused_readdata;

    assign unused_readdata = ^m_readdata;

    // vga_vs is asynchronous: two flops to resolve metastability, a third for edge detect
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vs_meta_q    <= 1'b1;
            vs_sync_q    <= 1'b1;
            vs_prev_q    <= 1'b1;
            frame_tick_q <= 1'b0;
        end else begin
            vs_meta_q    <= vga_vs;
            vs_sync_q    <= vs_meta_q;
            vs_prev_q    <= vs_sync_q;
            frame_tick_q <= vs_prev_q & ~vs_sync_q;
        end
    end

    assign frame_tick   = frame_tick_q;
    assign host_wr      = ~s_cs_n & s_write;
    assign host_rd      = ~s_cs_n & s_read;
    assign busy         = (state_q != IDLE);
    assign dwell_eff    = (dwell_q == 8'd0) ? 8'd1 : dwell_q;
    assign dwell_hit    = ({1'b0, frame_cnt_q} + 9'd1) >= {1'b0, dwell_eff};
    assign next_pattern = (cur_pattern_q >= LAST_PAT) ? 3'd0 : cur_pattern_q + 3'd1;

    always_comb begin
        rd_mux = 8'h00;
        case (s_address)
            2'd0: rd_mux = {7'b0, auto_en_q};
            2'd1: rd_mux = {5'b0, manual_q};
            2'd2: rd_mux = dwell_q;
            2'd3: rd_mux = {err_q, busy, manual_pending_q, 2'b00, cur_pattern_q};
            default: rd_mux = 8'h00;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (frame_tick_q && (manual_pending_q || (auto_en_q && dwell_hit)))
                      state_d = WR;
`ifdef VPG_SEQ_READBACK_EN
            WR:   state_d = RD;
`else
            WR:   state_d = IDLE;
`endif
            RD:   state_d = CHK;
            CHK:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        m_cs_n      = 1'b1;
        m_write     = 1'b0;
        m_read      = 1'b0;
        m_writedata = 8'h00;
        case (state_q)
            WR: begin
                m_cs_n      = 1'b0;
                m_write     = 1'b1;
                m_writedata = {5'b0, target_q};
            end
            RD: begin
                m_cs_n = 1'b0;
                m_read = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        auto_en_d        = auto_en_q;
        manual_d         = manual_q;
        manual_pending_d = manual_pending_q;
        dwell_d          = dwell_q;
        cur_pattern_d    = cur_pattern_q;
        frame_cnt_d      = frame_cnt_q;
        err_d            = err_q;
        target_d         = target_q;
        s_readdata_d     = s_readdata_q;

        // Ticks arriving mid-sequence are deliberately dropped, not counted
        if (state_q == IDLE && frame_tick_q) begin
            if (manual_pending_q) begin
                target_d         = manual_q;
                manual_pending_d = 1'b0;
            end else if (auto_en_q) begin
                if (dwell_hit) begin
                    target_d    = next_pattern;
                    frame_cnt_d = 8'd0;
                end else begin
                    frame_cnt_d = frame_cnt_q + 8'd1;
                end
            end
        end

        if (state_q == WR) cur_pattern_d = target_q;
`ifdef VPG_SEQ_READBACK_EN
        if (state_q == CHK && m_readdata[2:0] != cur_pattern_q) err_d = 1'b1;
`endif

        // Host accesses are applied last so a coincident write overrides the scheduler
        if (host_wr && s_address == 2'd0) begin
            auto_en_d = s_writedata[0];
            if (!s_writedata[0] || !auto_en_q) frame_cnt_d = 8'd0;
            if (s_writedata[1]) err_d = 1'b0;
        end
        if (host_wr && s_address == 2'd1) begin
            manual_d         = s_writedata[2:0];
            manual_pending_d = 1'b1;
            auto_en_d        = 1'b0;
            frame_cnt_d      = 8'd0;
        end
        if (host_wr && s_address == 2'd2) dwell_d = s_writedata;
        if (host_rd) s_readdata_d = rd_mux;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            auto_en_q        <= 1'b0;
            manual_q         <= 3'd0;
            manual_pending_q <= 1'b0;
            dwell_q          <= DEFAULT_DWELL;
            cur_pattern_q    <= 3'd0;
            frame_cnt_q      <= 8'd0;
            err_q            <= 1'b0;
            target_q         <= 3'd0;
            s_readdata_q     <= 8'h00;
        end else begin
            auto_en_q        <= auto_en_d;
            manual_q         <= manual_d;
            manual_pending_q <= manual_pending_d;
            dwell_q          <= dwell_d;
            cur_pattern_q    <= cur_pattern_d;
            frame_cnt_q      <= frame_cnt_d;
            err_q            <= err_d;
            target_q         <= target_d;
            s_readdata_q     <= s_readdata_d;
        end
    end

    assign s_readdata = s_readdata_q;

endmodule
